// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared definitions for the audio sample buffer: PCM sample
//               width, the playback state encoding, the silence code and a
//               saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int PCM_W = 16;

    // PRIMING: waiting for the FIFO to fill before (re)starting playback.
    // RUNNING: one sample is handed to the serializer per LRCK edge.
    typedef enum logic [0:0] {
        PRIMING = 1'b0,
        RUNNING = 1'b1
    } state_e;

    localparam logic [PCM_W-1:0] SILENCE = 16'h0000;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage : audio_pkg
`default_nettype wire

// File: rtl/audio_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : audio_fifo_ram
// Description : DEPTH x PCM_W sample storage. Registered write, asynchronous
//               read by pointer. No reset: stale contents are never observed
//               because the owner tracks occupancy with its own pointers.
// Ports       : clk      - rising-edge clock
//               we_i     - write enable
//               waddr_i  - write pointer
//               wdata_i  - sample to write
//               raddr_i  - read pointer
//               rdata_o  - sample at read pointer (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module audio_fifo_ram
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [PCM_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [PCM_W-1:0] rdata_o
);

    logic [PCM_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A write lands on the clock edge, so a sample is readable only from the
    // cycle after it was written.
    assign rdata_o = mem_q[raddr_i];

endmodule : audio_fifo_ram
`default_nettype wire

// File: rtl/audio_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_buffer
// Description : Elastic PCM buffer in front of the I2S DAC serializer. Samples
//               arrive over a valid/ready stream into a FIFO; every LRCK edge
//               requests the next sample, which is presented on pcm_out one
//               clock later. A priming FSM waits for PRIME samples before
//               playback starts and falls back to priming on underrun, where
//               silence is output and a saturating counter is bumped.
// Ports       : clk            - MCLK-domain clock, rising edge
//               reset          - asynchronous active-high reset
//               s_data/s_valid - incoming sample stream
//               s_ready        - FIFO not full
//               lrck           - DAC LRCK (same clock domain)
//               mute           - output silence, FIFO still drains
//               pcm_out        - sample for the serializer, held between edges
//               level          - FIFO occupancy 0..DEPTH
//               playing        - high while RUNNING
//               underrun       - one-cycle pulse per underrun
//               underrun_count - saturating underrun count
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_buffer
    import audio_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  PRIME = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PCM_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             lrck,
    input  logic             mute,
    output logic [PCM_W-1:0] pcm_out,
    output logic [AW:0]      level,
    output logic             playing,
    output logic             underrun,
    output logic [15:0]      underrun_count
);

    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_PRIME = (AW+1)'(PRIME);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,  state_d;
    logic             lrck_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q,  level_d;
    logic [PCM_W-1:0] pcm_q,    pcm_d;
    logic             under_q,  under_d;
    logic [15:0]      ucnt_q,   ucnt_d;

    logic             req;
    logic             push;
    logic             pop;
    logic [PCM_W-1:0] head;

    // One request per LRCK edge, either direction: one sample per slot.
    assign req  = lrck ^ lrck_q;

    // Readiness depends on the registered level only, so it has no
    // combinational path from s_valid or lrck. When full, a same-cycle pop
    // does not open the door for a push; the push lands one cycle later.
    assign s_ready = (level_q != LVL_FULL);
    assign push    = s_valid && s_ready;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    audio_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // ------------------------------------------------------------------
    // FSM and output sample selection
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        pcm_d   = pcm_q;
        under_d = 1'b0;
        ucnt_d  = ucnt_q;

        unique case (state_q)
            PRIMING: begin
                // Requests during priming still advance the serializer, so
                // they are answered with silence rather than ignored.
                if (req) begin
                    pcm_d = SILENCE;
                end
                if (level_q >= LVL_PRIME) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (req) begin
                    if (level_q != '0) begin
                        // Mute only masks the data; the sample is consumed
                        // so timing stays locked to the source.
                        pop   = 1'b1;
                        pcm_d = mute ? SILENCE : head;
                    end else begin
                        pcm_d   = SILENCE;
                        under_d = 1'b1;
                        ucnt_d  = sat_inc16(ucnt_q);
                        state_d = PRIMING;
                    end
                end
            end
            default: begin
                state_d = PRIMING;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PRIMING;
            lrck_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pcm_q    <= SILENCE;
            under_q  <= 1'b0;
            ucnt_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            lrck_q   <= lrck;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pcm_q    <= pcm_d;
            under_q  <= under_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign pcm_out        = pcm_q;
    assign level          = level_q;
    assign playing        = (state_q == RUNNING);
    assign underrun       = under_q;
    assign underrun_count = ucnt_q;

endmodule : audio_sample_buffer
`default_nettype wire

// File: doc/audio_sample_buffer.md
# audio_sample_buffer

Elastic sample buffer that sits directly upstream of the I2S DAC serializer. It accepts 16-bit PCM samples from the audio source over a valid/ready stream and holds them in a FIFO. On every DAC LRCK transition it presents the next sample on `pcm_out`, which drives the serializer's `pcm_in`. A priming state machine absorbs producer jitter. Underruns are replaced with silence and counted.

## Interface
- `DEPTH`, 16: FIFO depth in samples; power of two, ≥4.
- `PRIME`, 8: fill level required before playback (re)starts; 1 ≤ PRIME ≤ DEPTH.
- `AW`, $clog2(DEPTH): address width (derived, not overridden).

- `clk`  in  1  system clock, the 12.288 MHz MCLK domain; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_data`  in  16  signed PCM sample from source.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  buffer can accept; equals (level != DEPTH).
- `lrck`  in  1  DAC LRCK from serializer (same clock domain, no synchronizer).
- `mute`  in  1  force silence on output; FIFO keeps draining.
- `pcm_out`  out  16  sample to serializer `pcm_in`; held between requests.
- `level`  out  AW+1  current FIFO occupancy, 0..DEPTH.
- `playing`  out  1  high in RUNNING state.
- `underrun`  out  1  one-cycle pulse per underrun event.
- `underrun_count`  out  16  saturating underrun counter.

## Operation
- Push: `s_valid && s_ready` writes `s_data` at the write pointer and increments level.
- Request: `req = lrck ^ lrck_q`, where `lrck_q` is `lrck` registered.
  - One request is generated per LRCK edge, rising or falling, so there is one sample per channel slot.
- FSM states: PRIMING, RUNNING.
  - PRIMING → RUNNING when level ≥ PRIME, evaluated every cycle.
  - RUNNING → PRIMING on a request with level == 0.
- Request while RUNNING with level > 0: pop the head. `pcm_out` gets the head, or 16'h0000 if `mute` is high.
- Request while RUNNING with level == 0:
  - `pcm_out` gets 0.
  - `underrun` pulses.
  - `underrun_count` increments, saturating at 16'hFFFF.
  - State goes to PRIMING.
- Request while PRIMING: `pcm_out` gets 0, no pop, no underrun.
- Push and pop in the same cycle: both take effect and level is unchanged.
  - At level == DEPTH, `s_ready` is low, so no push occurs even if a pop happens that cycle.
- Pointers wrap modulo DEPTH. Level is tracked explicitly in AW+1 bits, which distinguishes full from empty.
- `mute` has no effect on state, level or underrun detection.

## Timing
- Reset values:
  - `pcm_out`=0, `level`=0, `playing`=0, `underrun`=0, `underrun_count`=0.
  - `s_ready`=1, `lrck_q`=0, state=PRIMING, pointers=0.
- If `lrck` is high when reset releases, one request fires on the first clock. It is handled as a PRIMING request.
- Latency:
  - `pcm_out` and `underrun` update on the clock edge after the cycle where `lrck` differs from `lrck_q`. That is 1 clk after the LRCK change, well before the serializer's next load.
  - Samples are therefore presented one channel slot ahead of serialization.
- `level`, `s_ready` and `playing` are registered or derived from registers. `s_ready` has no combinational path from `s_valid` or `lrck`.
- A push written on cycle N is poppable from cycle N+1. A pop cannot return a sample pushed in the same cycle.
- `reset` mid-operation: FIFO contents are discarded. The counter clears, and all outputs return to reset values immediately (asynchronous).

## Structure
- Shared package `audio_pkg`: `PCM_W`=16, the FSM state enum (PRIMING, RUNNING), and `SILENCE`=16'h0000.
- Sub-module `audio_fifo_ram`: DEPTH×16 storage with registered write and asynchronous read by pointer.
- Pointers, level, FSM and request logic live in the top.

## Test plan
- Priming: DEPTH=16, PRIME=8.
  - Push 7 samples, toggle `lrck` 3×: `pcm_out` stays 0, `playing`=0, level=7.
  - Push an 8th sample: `playing`=1 next cycle.
- Ordering: push 16'h0001..16'h0010, then toggle `lrck` 16×.
  - `pcm_out` sequence is 0001..0010.
  - `s_ready` is low while level=16.
- Underrun: in RUNNING with 1 sample left, toggle `lrck` twice.
  - 2nd request gives `pcm_out`=0 and a single `underrun` pulse, count=1, state PRIMING.
  - Saturation: preload the count near 16'hFFFF via repeated underruns; it must stick at 16'hFFFF.
- Simultaneous: at level=16, hold `s_valid` and pulse `lrck`.
  - Level goes to 15, with no push that cycle.
  - Next cycle the push is accepted and level=16.
  - At level=5, a push plus request in one cycle keeps level=5.
- Mute: with `mute`=1 in RUNNING, 4 requests give `pcm_out`=0 and level drops by 4. After `mute`=0 the 5th sample appears.
- Reset mid-stream: assert `reset` with level=9.
  - All outputs return to reset values asynchronously.
  - After release, behaviour matches a fresh priming sequence.
